// File: rtl/issue_queue_pkg.sv
// Shared types and sizing for the decode-to-issue queue.
// IQ_ADDR must be wide enough to hold a count of 0..IQ_DEPTH inclusive.
package issue_queue_pkg;

  localparam int IQ_DEPTH  = 16;
  localparam int IQ_ADDR_W = $clog2(IQ_DEPTH) + 1;

  typedef logic [IQ_ADDR_W-1:0] IQ_ADDR;
  typedef logic bool;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ISSUE_QUEUE_ELEMENT;

endpackage

// File: rtl/iq_ram.sv
// Register array backing the issue queue.
// It has two write ports, two combinational read ports and an async active-low clear.
module iq_ram
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  ISSUE_QUEUE_ELEMENT       wdata0,
  input  ISSUE_QUEUE_ELEMENT       wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output ISSUE_QUEUE_ELEMENT       rdata0,
  output ISSUE_QUEUE_ELEMENT       rdata1
);

  localparam int AW = $clog2(DEPTH);

  ISSUE_QUEUE_ELEMENT [DEPTH-1:0] mem;

  // The two write addresses are always tail and tail+1, so they never collide.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mem[gi] <= '0;
        end else if (we1 && waddr1 == AW'(gi)) begin
          mem[gi] <= wdata1;
        end else if (we0 && waddr0 == AW'(gi)) begin
          mem[gi] <= wdata0;
        end
      end
    end
  endgenerate

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/issue_queue.sv
// In-order circular issue queue: it accepts up to two entries per cycle and presents the two oldest.
// Issue pops entries by returning a count; flush empties the queue on a redirect.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH = issue_queue_pkg::IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_number,
  input  ISSUE_QUEUE_ELEMENT [1:0] push_data,
  output logic                     iq_ready,
  output ISSUE_QUEUE_ELEMENT [1:0] issue_require,
  output IQ_ADDR                   iq_size,
  input  logic [1:0]               iq_pop_number
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    push_eff, pop_eff;
  logic          we0, we1;
  ISSUE_QUEUE_ELEMENT rdata0, rdata1;

  // Ready comes from the registered count only, so slots freed by a pop open up one cycle later.
  assign iq_ready = (count_reg <= CW'(IQ_DEPTH - 2));

  always_comb begin
    push_eff = 2'd0;
    if (iq_ready) begin
      push_eff = (push_number == 2'd3) ? 2'd2 : push_number;
    end
    pop_eff = (iq_pop_number == 2'd3) ? 2'd2 : iq_pop_number;
    if (CW'(pop_eff) > count_reg) begin
      pop_eff = count_reg[1:0];
    end
    head_next  = head_reg + PW'(pop_eff);
    tail_next  = tail_reg + PW'(push_eff);
    count_next = count_reg + CW'(push_eff) - CW'(pop_eff);
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign we0 = !flush && (push_eff != 2'd0);
  assign we1 = !flush && (push_eff == 2'd2);

  iq_ram #(
    .DEPTH(IQ_DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we0    (we0),
    .we1    (we1),
    .waddr0 (tail_reg),
    .waddr1 (tail_reg + PW'(1)),
    .wdata0 (push_data[0]),
    .wdata1 (push_data[1]),
    .raddr0 (head_reg),
    .raddr1 (head_reg + PW'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  assign issue_require[0] = (count_reg != '0)      ? rdata0 : '0;
  assign issue_require[1] = (count_reg >= CW'(2))  ? rdata1 : '0;
  assign iq_size          = IQ_ADDR'(count_reg);

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with IQ_DEPTH = 16 and hand-computed expectations.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [1:0] push_number = 2'd0;
  ISSUE_QUEUE_ELEMENT [1:0] push_data = '0;
  logic iq_ready;
  ISSUE_QUEUE_ELEMENT [1:0] issue_require;
  IQ_ADDR iq_size;
  logic [1:0] iq_pop_number = 2'd0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  issue_queue #(.IQ_DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .push_number   (push_number),
    .push_data     (push_data),
    .iq_ready      (iq_ready),
    .issue_require (issue_require),
    .iq_size       (iq_size),
    .iq_pop_number (iq_pop_number)
  );

  function automatic ISSUE_QUEUE_ELEMENT mk(input int id);
    ISSUE_QUEUE_ELEMENT e;
    e.pc   = 32'h1000 + 32'(id) * 32'd4;
    e.inst = 32'hA000_0000 | 32'(id);
    return e;
  endfunction

  // Applies one cycle of stimulus, waits for the edge, samples at #1 and returns the inputs to idle.
  task automatic step(input logic [1:0] pn, input int d0, input int d1,
                      input logic [1:0] pop, input logic fl);
    push_number   = pn;
    push_data[0]  = mk(d0);
    push_data[1]  = mk(d1);
    iq_pop_number = pop;
    flush         = fl;
    @(posedge clk);
    #1;
    push_number   = 2'd0;
    push_data     = '0;
    iq_pop_number = 2'd0;
    flush         = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    if (iq_size !== IQ_ADDR'(0)) begin n_fail++; $display("FAIL reset_size got %0d want 0", iq_size); end
    n_checks++;
    if (iq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", iq_ready); end
    n_checks++;
    if (issue_require !== '0) begin n_fail++; $display("FAIL reset_req got %h want 0", issue_require); end
    n_checks++;
    step(2'd2, 1, 2, 2'd0, 1'b0);
    step(2'd2, 3, 4, 2'd0, 1'b0);
    step(2'd1, 5, 0, 2'd0, 1'b0);
    if (iq_size !== IQ_ADDR'(5)) begin n_fail++; $display("FAIL prefill_size got %0d want 5", iq_size); end
    n_checks++;
    #2 rst = 1'b0;
    #1;
    if (iq_size !== IQ_ADDR'(0)) begin n_fail++; $display("FAIL async_rst_size got %0d want 0", iq_size); end
    n_checks++;
    if (iq_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready got %b want 1", iq_ready); end
    n_checks++;
    if (issue_require !== '0) begin n_fail++; $display("FAIL async_rst_req got %h want 0", issue_require); end
    n_checks++;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    if (iq_size !== IQ_ADDR'(0)) begin n_fail++; $display("FAIL post_rst_size got %0d want 0", iq_size); end
    n_checks++;
    $display("reset: checks so far %0d", n_checks);
  endtask

  task automatic test_dual_push_pop;
    // push_number of 3 is treated as a push of 2.
    step(2'd3, 10, 11, 2'd0, 1'b0);
    if (iq_size !== IQ_ADDR'(2)) begin n_fail++; $display("FAIL dual_size got %0d want 2", iq_size); end
    n_checks++;
    if (issue_require[0] !== mk(10)) begin n_fail++; $display("FAIL dual_req0 got %h want %h", issue_require[0], mk(10)); end
    n_checks++;
    if (issue_require[1] !== mk(11)) begin n_fail++; $display("FAIL dual_req1 got %h want %h", issue_require[1], mk(11)); end
    n_checks++;
    step(2'd0, 0, 0, 2'd2, 1'b0);
    if (iq_size !== IQ_ADDR'(0)) begin n_fail++; $display("FAIL dual_pop_size got %0d want 0", iq_size); end
    n_checks++;
    if (issue_require !== '0) begin n_fail++; $display("FAIL dual_pop_req got %h want 0", issue_require); end
    n_checks++;
    $display("dual push/pop: checks so far %0d", n_checks);
  endtask

  task automatic test_single_entry;
    step(2'd1, 20, 99, 2'd0, 1'b0);
    if (iq_size !== IQ_ADDR'(1)) begin n_fail++; $display("FAIL single_size got %0d want 1", iq_size); end
    n_checks++;
    if (issue_require[0] !== mk(20)) begin n_fail++; $display("FAIL single_req0 got %h want %h", issue_require[0], mk(20)); end
    n_checks++;
    if (issue_require[1] !== '0) begin n_fail++; $display("FAIL single_req1 got %h want 0", issue_require[1]); end
    n_checks++;
    step(2'd0, 0, 0, 2'd2, 1'b0);
    if (iq_size !== IQ_ADDR'(0)) begin n_fail++; $display("FAIL clamp_size got %0d want 0", iq_size); end
    n_checks++;
    // If the head had advanced by 2, it would no longer line up with the tail.
    step(2'd2, 21, 22, 2'd0, 1'b0);
    if (issue_require[0] !== mk(21)) begin n_fail++; $display("FAIL clamp_head_req0 got %h want %h", issue_require[0], mk(21)); end
    n_checks++;
    if (issue_require[1] !== mk(22)) begin n_fail++; $display("FAIL clamp_head_req1 got %h want %h", issue_require[1], mk(22)); end
    n_checks++;
    $display("single entry: checks so far %0d", n_checks);
  endtask

  task automatic test_full;
    step(2'd0, 0, 0, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(2'd2, 30 + 2 * i, 31 + 2 * i, 2'd0, 1'b0);
    if (iq_size !== IQ_ADDR'(16)) begin n_fail++; $display("FAIL full_size got %0d want 16", iq_size); end
    n_checks++;
    if (iq_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", iq_ready); end
    n_checks++;
    step(2'd2, 90, 91, 2'd0, 1'b0);
    if (iq_size !== IQ_ADDR'(16)) begin n_fail++; $display("FAIL full_ignore_size got %0d want 16", iq_size); end
    n_checks++;
    if (issue_require[0] !== mk(30)) begin n_fail++; $display("FAIL full_ignore_req0 got %h want %h", issue_require[0], mk(30)); end
    n_checks++;
    // A pop and a push in the same full cycle: the slots freed by the pop are not yet usable.
    step(2'd2, 92, 93, 2'd2, 1'b0);
    if (iq_size !== IQ_ADDR'(14)) begin n_fail++; $display("FAIL full_pop_size got %0d want 14", iq_size); end
    n_checks++;
    if (iq_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready got %b want 1", iq_ready); end
    n_checks++;
    if (issue_require[0] !== mk(32)) begin n_fail++; $display("FAIL full_pop_req0 got %h want %h", issue_require[0], mk(32)); end
    n_checks++;
    if (issue_require[1] !== mk(33)) begin n_fail++; $display("FAIL full_pop_req1 got %h want %h", issue_require[1], mk(33)); end
    n_checks++;
    $display("full: checks so far %0d", n_checks);
  endtask

  task automatic test_wrap;
    step(2'd0, 0, 0, 2'd0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(2'd1, 40 + i, 0, 2'd0, 1'b0);
      step(2'd0, 0, 0, 2'd1, 1'b0);
    end
    if (iq_size !== IQ_ADDR'(0)) begin n_fail++; $display("FAIL wrap_pre_size got %0d want 0", iq_size); end
    n_checks++;
    step(2'd2, 60, 61, 2'd0, 1'b0);
    if (issue_require[0] !== mk(60)) begin n_fail++; $display("FAIL wrap_req0 got %h want %h", issue_require[0], mk(60)); end
    n_checks++;
    if (issue_require[1] !== mk(61)) begin n_fail++; $display("FAIL wrap_req1 got %h want %h", issue_require[1], mk(61)); end
    n_checks++;
    // Pop one and push two in the same cycle; the pop removes P, which was present before the edge.
    step(2'd2, 62, 63, 2'd1, 1'b0);
    if (iq_size !== IQ_ADDR'(3)) begin n_fail++; $display("FAIL wrap_mix_size got %0d want 3", iq_size); end
    n_checks++;
    if (issue_require[0] !== mk(61)) begin n_fail++; $display("FAIL wrap_mix_req0 got %h want %h", issue_require[0], mk(61)); end
    n_checks++;
    if (issue_require[1] !== mk(62)) begin n_fail++; $display("FAIL wrap_mix_req1 got %h want %h", issue_require[1], mk(62)); end
    n_checks++;
    $display("wrap: checks so far %0d", n_checks);
  endtask

  task automatic test_flush_collision;
    step(2'd0, 0, 0, 2'd0, 1'b1);
    step(2'd2, 70, 71, 2'd0, 1'b0);
    step(2'd2, 72, 73, 2'd0, 1'b0);
    step(2'd2, 74, 75, 2'd0, 1'b0);
    if (iq_size !== IQ_ADDR'(6)) begin n_fail++; $display("FAIL flush_pre_size got %0d want 6", iq_size); end
    n_checks++;
    step(2'd2, 76, 77, 2'd2, 1'b1);
    if (iq_size !== IQ_ADDR'(0)) begin n_fail++; $display("FAIL flush_size got %0d want 0", iq_size); end
    n_checks++;
    if (iq_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", iq_ready); end
    n_checks++;
    if (issue_require !== '0) begin n_fail++; $display("FAIL flush_req got %h want 0", issue_require); end
    n_checks++;
    step(2'd1, 80, 0, 2'd0, 1'b0);
    if (issue_require[0] !== mk(80)) begin n_fail++; $display("FAIL flush_after_req0 got %h want %h", issue_require[0], mk(80)); end
    n_checks++;
    if (iq_size !== IQ_ADDR'(1)) begin n_fail++; $display("FAIL flush_after_size got %0d want 1", iq_size); end
    n_checks++;
    $display("flush collision: checks so far %0d", n_checks);
  endtask

  initial begin
    test_reset();
    test_dual_push_pop();
    test_single_entry();
    test_full();
    test_wrap();
    test_flush_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
